ex_redirect_unit: RTL and testbench

//  Resolves branches and jumps for the instruction leaving ID/EX and registers the result

---
 rtl/mips_defs_pkg.sv | 17 +
 rtl/redirect_resolve.sv | 38 +++
 rtl/ex_redirect_unit.sv | 123 ++++++++++++
 tb/tb_ex_redirect_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared encodings for the EX-stage redirect logic: jump and branch type codes.
package mips_defs;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JR   = 2'b10;

    localparam logic [1:0] BR_NONE  = 2'b00;
    localparam logic [1:0] BR_BEQ   = 2'b01;
    localparam logic [1:0] BR_BNE   = 2'b10;

    // Reserved jump code 11 is folded to JMP_NONE so it can never redirect.
    function automatic logic [1:0] legal_jump(input logic [1:0] code);
        return ((code == JMP_J) || (code == JMP_JR)) ? code : JMP_NONE;
    endfunction

endpackage

// File: rtl/redirect_resolve.sv
// Combinational decode of the ID/EX instruction: jump type, branch outcome and
// branch target. Everything is forced inactive for a bubble.
module redirect_resolve
    import mips_defs::*;
(
    input  logic        de_valid,
    input  logic [1:0]  de_branch,
    input  logic [1:0]  de_jump,
    input  logic [31:0] de_alu_a,
    input  logic [31:0] de_alu_b,
    input  logic [31:0] de_imm,
    input  logic [31:0] de_pcplus4,
    output logic [1:0]  jump_d,
    output logic        taken_d,
    output logic [31:0] target_d
);

    logic operands_equal;

    assign operands_equal = (de_alu_a == de_alu_b);

    // Jump wins over branch; reserved encodings decode as "none".
    always_comb begin
        jump_d  = JMP_NONE;
        taken_d = 1'b0;
        if (de_valid) begin
            jump_d = legal_jump(de_jump);
            if (jump_d == JMP_NONE) begin
                taken_d = ((de_branch == BR_BEQ) &&  operands_equal) ||
                          ((de_branch == BR_BNE) && !operands_equal);
            end
        end
    end

    // Word offset scaled to bytes; the add wraps modulo 2^32.
    assign target_d = de_pcplus4 + {de_imm[29:0], 2'b00};

endmodule

// File: rtl/ex_redirect_unit.sv
// EX/MEM redirect stage: registers the resolved branch/jump, squashes the
// wrong-path instruction behind a redirect, raises pipeline flushes and keeps
// a saturating redirect counter plus a sticky misaligned-jr debug flag.
module ex_redirect_unit
    import mips_defs::*;
#(
    parameter int CNT_W    = 16,
    parameter int JR_CHECK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             DE_valid,
    input  logic [1:0]       DE_branch,
    input  logic [1:0]       DE_jump,
    input  logic [31:0]      DE_alu_a,
    input  logic [31:0]      DE_alu_b,
    input  logic [31:0]      DE_imm,
    input  logic [25:0]      DE_JAddr,
    input  logic [31:0]      DE_PCPlus4,
    input  logic             stall,
    output logic [1:0]       EM_jump,
    output logic [31:0]      EM_alu_a,
    output logic [25:0]      EM_JAddr,
    output logic [31:0]      EM_PCPlus4,
    output logic             EM_PCSrc,
    output logic [31:0]      EM_PCBranch,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic             jr_misalign
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic             CHECK_JR = (JR_CHECK != 0);

    logic [1:0]       jump_d;
    logic             taken_d;
    logic [31:0]      target_d;

    logic             em_valid_reg;
    logic [1:0]       em_jump_reg;
    logic             em_pcsrc_reg;
    logic [31:0]      em_pcbranch_reg;
    logic [31:0]      em_alu_a_reg;
    logic [25:0]      em_jaddr_reg;
    logic [31:0]      em_pcplus4_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             misalign_reg;

    logic             em_redirect;
    logic             redirect_fire;

    redirect_resolve u_resolve (
        .de_valid   (DE_valid),
        .de_branch  (DE_branch),
        .de_jump    (DE_jump),
        .de_alu_a   (DE_alu_a),
        .de_alu_b   (DE_alu_b),
        .de_imm     (DE_imm),
        .de_pcplus4 (DE_PCPlus4),
        .jump_d     (jump_d),
        .taken_d    (taken_d),
        .target_d   (target_d)
    );

    // Control outputs are gated by EM_valid so a bubble never looks like a redirect.
    assign EM_jump     = em_valid_reg ? em_jump_reg : JMP_NONE;
    assign EM_PCSrc    = em_valid_reg & em_pcsrc_reg;
    assign EM_alu_a    = em_alu_a_reg;
    assign EM_JAddr    = em_jaddr_reg;
    assign EM_PCPlus4  = em_pcplus4_reg;
    assign EM_PCBranch = em_pcbranch_reg;

    assign em_redirect   = em_valid_reg & ((EM_jump != JMP_NONE) | EM_PCSrc);
    // A stalled redirect stays pending; it only takes effect on an unstalled edge.
    assign redirect_fire = em_redirect & ~stall;
    assign flush_IFID    = redirect_fire;
    assign flush_IDEX    = redirect_fire;

    assign redirect_cnt  = cnt_reg;
    assign jr_misalign   = misalign_reg;

    // EX/MEM register: hold on stall, squash the wrong-path instruction after a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_valid_reg    <= 1'b0;
            em_jump_reg     <= JMP_NONE;
            em_pcsrc_reg    <= 1'b0;
            em_pcbranch_reg <= '0;
            em_alu_a_reg    <= '0;
            em_jaddr_reg    <= '0;
            em_pcplus4_reg  <= '0;
        end else if (!stall) begin
            em_valid_reg    <= em_redirect ? 1'b0 : DE_valid;
            em_jump_reg     <= jump_d;
            em_pcsrc_reg    <= taken_d;
            em_pcbranch_reg <= target_d;
            em_alu_a_reg    <= DE_alu_a;
            em_jaddr_reg    <= DE_JAddr;
            em_pcplus4_reg  <= DE_PCPlus4;
        end
    end

    // Saturating count of redirects that actually took effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (redirect_fire && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + CNT_ONE;
        end
    end

    // Sticky flag for a committed jr whose target is not word aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_reg <= 1'b0;
        end else if (CHECK_JR && redirect_fire && (EM_jump == JMP_JR) &&
                     (em_alu_a_reg[1:0] != 2'b00)) begin
            misalign_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_redirect_unit.sv
// Bench for ex_redirect_unit: a table of single-instruction vectors checked
// through an expectation queue, plus stall, saturation and async-reset sequences.
module tb_ex_redirect_unit;

    logic        clk;
    logic        rst_n;
    logic        DE_valid;
    logic [1:0]  DE_branch;
    logic [1:0]  DE_jump;
    logic [31:0] DE_alu_a;
    logic [31:0] DE_alu_b;
    logic [31:0] DE_imm;
    logic [25:0] DE_JAddr;
    logic [31:0] DE_PCPlus4;
    logic        stall;

    logic [1:0]  EM_jump;
    logic [31:0] EM_alu_a;
    logic [25:0] EM_JAddr;
    logic [31:0] EM_PCPlus4;
    logic        EM_PCSrc;
    logic [31:0] EM_PCBranch;
    logic        flush_IFID;
    logic        flush_IDEX;
    logic [15:0] redirect_cnt;
    logic        jr_misalign;

    // Narrow-counter instance sharing the same stimulus, for saturation checks.
    logic [1:0]  s_EM_jump;
    logic [31:0] s_EM_alu_a;
    logic [25:0] s_EM_JAddr;
    logic [31:0] s_EM_PCPlus4;
    logic        s_EM_PCSrc;
    logic [31:0] s_EM_PCBranch;
    logic        s_flush_IFID;
    logic        s_flush_IDEX;
    logic [1:0]  s_redirect_cnt;
    logic        s_jr_misalign;

    int n_cmp = 0;
    int n_bad = 0;

    ex_redirect_unit #(.CNT_W(16), .JR_CHECK(1)) dut (
        .clk(clk), .rst_n(rst_n), .DE_valid(DE_valid), .DE_branch(DE_branch),
        .DE_jump(DE_jump), .DE_alu_a(DE_alu_a), .DE_alu_b(DE_alu_b), .DE_imm(DE_imm),
        .DE_JAddr(DE_JAddr), .DE_PCPlus4(DE_PCPlus4), .stall(stall),
        .EM_jump(EM_jump), .EM_alu_a(EM_alu_a), .EM_JAddr(EM_JAddr),
        .EM_PCPlus4(EM_PCPlus4), .EM_PCSrc(EM_PCSrc), .EM_PCBranch(EM_PCBranch),
        .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
        .redirect_cnt(redirect_cnt), .jr_misalign(jr_misalign)
    );

    ex_redirect_unit #(.CNT_W(2), .JR_CHECK(1)) dut_small (
        .clk(clk), .rst_n(rst_n), .DE_valid(DE_valid), .DE_branch(DE_branch),
        .DE_jump(DE_jump), .DE_alu_a(DE_alu_a), .DE_alu_b(DE_alu_b), .DE_imm(DE_imm),
        .DE_JAddr(DE_JAddr), .DE_PCPlus4(DE_PCPlus4), .stall(stall),
        .EM_jump(s_EM_jump), .EM_alu_a(s_EM_alu_a), .EM_JAddr(s_EM_JAddr),
        .EM_PCPlus4(s_EM_PCPlus4), .EM_PCSrc(s_EM_PCSrc), .EM_PCBranch(s_EM_PCBranch),
        .flush_IFID(s_flush_IFID), .flush_IDEX(s_flush_IDEX),
        .redirect_cnt(s_redirect_cnt), .jr_misalign(s_jr_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [1:0]  br;
        logic [1:0]  jmp;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [25:0] jaddr;
        logic [31:0] pc4;
        logic [1:0]  x_jump;
        logic        x_pcsrc;
        logic [31:0] x_pcbranch;
        logic        x_redir;
        logic [31:0] x_jpc;
    } vec_t;

    vec_t vecs[13];
    vec_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        DE_valid   = v.valid;
        DE_branch  = v.br;
        DE_jump    = v.jmp;
        DE_alu_a   = v.a;
        DE_alu_b   = v.b;
        DE_imm     = v.imm;
        DE_JAddr   = v.jaddr;
        DE_PCPlus4 = v.pc4;
    endtask

    task automatic drive_bubble();
        DE_valid  = 1'b0;
        DE_branch = 2'b00;
        DE_jump   = 2'b00;
    endtask

    // Rising edge, then sample 1 time unit later, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic valid, logic [1:0] br, logic [1:0] jmp,
                                logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                                logic [25:0] jaddr, logic [31:0] pc4,
                                logic [1:0] x_jump, logic x_pcsrc,
                                logic [31:0] x_pcbranch, logic x_redir,
                                logic [31:0] x_jpc);
        vec_t v;
        v.valid = valid; v.br = br; v.jmp = jmp; v.a = a; v.b = b; v.imm = imm;
        v.jaddr = jaddr; v.pc4 = pc4; v.x_jump = x_jump; v.x_pcsrc = x_pcsrc;
        v.x_pcbranch = x_pcbranch; v.x_redir = x_redir; v.x_jpc = x_jpc;
        return v;
    endfunction

    initial begin
        vec_t e;
        logic [31:0] exp_cnt;
        logic        exp_mis;
        logic [31:0] jpc;

        //            vld br     jmp    A             B         imm           jaddr     pc4            xjmp  xsrc xbranch       xred xjpc
        vecs[0]  = mk(1, 2'b01, 2'b00, 32'd5,        32'd5,    32'd3,        26'h0,    32'h0000_0100, 2'b00, 1, 32'h0000_010C, 1, 32'h0);
        vecs[1]  = mk(1, 2'b10, 2'b00, 32'd7,        32'd7,    32'd4,        26'h0,    32'h0000_0200, 2'b00, 0, 32'h0000_0210, 0, 32'h0);
        vecs[2]  = mk(1, 2'b00, 2'b01, 32'd0,        32'd0,    32'd0,        26'h40,   32'hA000_0010, 2'b01, 0, 32'hA000_0010, 1, 32'hA000_0100);
        vecs[3]  = mk(1, 2'b00, 2'b10, 32'h0040_0004,32'd0,    32'd0,        26'h0,    32'h0000_0300, 2'b10, 0, 32'h0000_0300, 1, 32'h0);
        vecs[4]  = mk(1, 2'b00, 2'b10, 32'h0040_0003,32'd0,    32'd0,        26'h0,    32'h0000_0304, 2'b10, 0, 32'h0000_0304, 1, 32'h0);
        vecs[5]  = mk(1, 2'b01, 2'b00, 32'd1,        32'd2,    32'hFFFF_FFFF,26'h0,    32'h0000_0400, 2'b00, 0, 32'h0000_03FC, 0, 32'h0);
        vecs[6]  = mk(1, 2'b10, 2'b00, 32'd1,        32'd2,    32'h10,       26'h0,    32'h0000_0500, 2'b00, 1, 32'h0000_0540, 1, 32'h0);
        vecs[7]  = mk(1, 2'b00, 2'b11, 32'd9,        32'd9,    32'd0,        26'h3,    32'h0000_0600, 2'b00, 0, 32'h0000_0600, 0, 32'h0);
        vecs[8]  = mk(1, 2'b11, 2'b00, 32'd9,        32'd9,    32'd0,        26'h0,    32'h0000_0700, 2'b00, 0, 32'h0000_0700, 0, 32'h0);
        vecs[9]  = mk(1, 2'b01, 2'b11, 32'd4,        32'd4,    32'd1,        26'h0,    32'h0000_0800, 2'b00, 1, 32'h0000_0804, 1, 32'h0);
        vecs[10] = mk(0, 2'b00, 2'b01, 32'd0,        32'd0,    32'd0,        26'h11,   32'h0000_0880, 2'b00, 0, 32'h0000_0880, 0, 32'h0);
        vecs[11] = mk(1, 2'b01, 2'b01, 32'd6,        32'd6,    32'd2,        26'h10,   32'h0000_0900, 2'b01, 0, 32'h0000_0908, 1, 32'h0000_0040);
        vecs[12] = mk(1, 2'b01, 2'b00, 32'd3,        32'd3,    32'd1,        26'h0,    32'hFFFF_FFFC, 2'b00, 1, 32'h0000_0000, 1, 32'h0);

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        stall = 1'b0;
        DE_alu_a = '0; DE_alu_b = '0; DE_imm = '0; DE_JAddr = '0; DE_PCPlus4 = '0;
        drive_bubble();
        #2;
        chk("rst_EM_jump", {30'd0, EM_jump}, 32'd0);
        chk("rst_EM_PCSrc", {31'd0, EM_PCSrc}, 32'd0);
        chk("rst_EM_PCBranch", EM_PCBranch, 32'd0);
        chk("rst_EM_alu_a", EM_alu_a, 32'd0);
        chk("rst_flush", {30'd0, flush_IFID, flush_IDEX}, 32'd0);
        chk("rst_cnt", {16'd0, redirect_cnt}, 32'd0);
        chk("rst_misalign", {31'd0, jr_misalign}, 32'd0);
        #10;
        rst_n = 1'b1;
        tick();

        // ---------------- table-driven vectors ----------------
        exp_cnt = 0;
        exp_mis = 1'b0;
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            tick();
            e = exp_q.pop_front();
            $display("vec %0d: EM_jump=%0d EM_PCSrc=%0d EM_PCBranch=0x%08h flush=%0d cnt=%0d",
                     i, EM_jump, EM_PCSrc, EM_PCBranch, flush_IFID, redirect_cnt);
            chk($sformatf("v%0d_EM_jump", i), {30'd0, EM_jump}, {30'd0, e.x_jump});
            chk($sformatf("v%0d_EM_PCSrc", i), {31'd0, EM_PCSrc}, {31'd0, e.x_pcsrc});
            chk($sformatf("v%0d_EM_PCBranch", i), EM_PCBranch, e.x_pcbranch);
            chk($sformatf("v%0d_EM_alu_a", i), EM_alu_a, e.a);
            chk($sformatf("v%0d_EM_JAddr", i), {6'd0, EM_JAddr}, {6'd0, e.jaddr});
            chk($sformatf("v%0d_EM_PCPlus4", i), EM_PCPlus4, e.pc4);
            chk($sformatf("v%0d_flush_IFID", i), {31'd0, flush_IFID}, {31'd0, e.x_redir});
            chk($sformatf("v%0d_flush_IDEX", i), {31'd0, flush_IDEX}, {31'd0, e.x_redir});
            if (e.x_jump == 2'b01) begin
                jpc = {EM_PCPlus4[31:28], EM_JAddr, 2'b00};
                chk($sformatf("v%0d_jump_pc", i), jpc, e.x_jpc);
            end
            if (e.x_redir) begin
                exp_cnt = exp_cnt + 1;
                if (e.x_jump == 2'b10 && e.a[1:0] != 2'b00) exp_mis = 1'b1;
            end
            // Separator bubble: the redirect (if any) resolves on this edge.
            drive_bubble();
            tick();
            chk($sformatf("v%0d_after_jump", i), {30'd0, EM_jump}, 32'd0);
            chk($sformatf("v%0d_after_flush", i), {31'd0, flush_IFID}, 32'd0);
            chk($sformatf("v%0d_cnt", i), {16'd0, redirect_cnt}, exp_cnt);
            chk($sformatf("v%0d_cnt_small", i), {30'd0, s_redirect_cnt},
                (exp_cnt > 3) ? 32'd3 : exp_cnt);
            chk($sformatf("v%0d_misalign", i), {31'd0, jr_misalign}, {31'd0, exp_mis});
        end

        // ---------------- stall holds a pending redirect ----------------
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        drive(vecs[0]);
        tick();
        drive_bubble();
        stall = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            $display("stall cycle %0d: EM_PCSrc=%0d flush=%0d cnt=%0d", c, EM_PCSrc, flush_IFID, redirect_cnt);
            chk($sformatf("stall%0d_flush", c), {31'd0, flush_IFID}, 32'd0);
            chk($sformatf("stall%0d_PCSrc", c), {31'd0, EM_PCSrc}, 32'd1);
            chk($sformatf("stall%0d_cnt", c), {16'd0, redirect_cnt}, 32'd0);
            tick();
        end
        stall = 1'b0;
        #1;
        chk("unstall_flush", {31'd0, flush_IDEX}, 32'd1);
        tick();
        $display("unstall: EM_PCSrc=%0d flush=%0d cnt=%0d", EM_PCSrc, flush_IFID, redirect_cnt);
        chk("unstall_cnt", {16'd0, redirect_cnt}, 32'd1);
        chk("unstall_bubble", {31'd0, EM_PCSrc}, 32'd0);
        chk("unstall_flush_gone", {31'd0, flush_IFID}, 32'd0);

        // ---------------- saturation with CNT_W=2 ----------------
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        drive(vecs[0]);
        for (int c = 1; c <= 8; c++) begin
            tick();
            $display("sat edge %0d: cnt=%0d small_cnt=%0d", c, redirect_cnt, s_redirect_cnt);
            if (c == 6) chk("sat_small_e6", {30'd0, s_redirect_cnt}, 32'd3);
        end
        chk("sat_small_e8", {30'd0, s_redirect_cnt}, 32'd3);
        chk("sat_wide_e8", {16'd0, redirect_cnt}, 32'd4);

        // ---------------- asynchronous reset mid-run ----------------
        drive(vecs[2]);
        tick();
        chk("pre_rst_jump", {30'd0, EM_jump}, 32'd1);
        drive_bubble();
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: EM_jump=%0d flush=%0d cnt=%0d", EM_jump, flush_IFID, redirect_cnt);
        chk("arst_jump", {30'd0, EM_jump}, 32'd0);
        chk("arst_flush", {30'd0, flush_IFID, flush_IDEX}, 32'd0);
        chk("arst_cnt", {16'd0, redirect_cnt}, 32'd0);
        chk("arst_small_cnt", {30'd0, s_redirect_cnt}, 32'd0);
        chk("arst_JAddr", {6'd0, EM_JAddr}, 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_flush", {31'd0, flush_IFID}, 32'd0);
        tick();
        chk("post_rst_edge_flush", {31'd0, flush_IFID}, 32'd0);
        chk("post_rst_edge_cnt", {16'd0, redirect_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
